// File: rtl/fisr_newton_iter.sv
// fisr_newton_iter
//   Fast inverse square root core for FP32. Forms the magic-constant initial
//   guess, then runs ITER Newton-Raphson steps y <- y*(1.5 - x/2*y*y) on one
//   shared multiplier and one shared subtractor, sequenced by a small FSM.
//   IEEE special inputs (zero/denormal, negative, +Inf, NaN) bypass the
//   iteration and are reported with m_special.
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-low reset
//   ce             clock enable; every register holds while low
//   s_valid/ready  input handshake, s_data = FP32 operand x
//   m_valid/ready  output handshake, m_data = ~1/sqrt(x)
//   m_special      result came from the special-case path
module fisr_newton_iter #(
  parameter int          ITER  = 2,             // 1..4
  parameter logic [31:0] MAGIC = 32'h5F3759DF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_special
);

  typedef enum logic [2:0] {IDLE, MUL_A, MUL_B, SUB, MUL_C, DONE} state_e;

  localparam logic [31:0] FP_1P5  = 32'h3FC00000;
  localparam logic [31:0] FP_INF  = 32'h7F800000;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [2:0]  ITER_W  = 3'(ITER);

  // Truncating FP32 multiply. Denormal operands count as zero, underflow
  // flushes to +0, overflow saturates to signed Inf.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] f;
    logic        s;
    s = a[31] ^ b[31];
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} + {9'd0, p[47]};
    // product of two [1,2) mantissas lies in [1,4): at most one shift
    f = 23'((p[47] ? p[46:0] : {p[45:0], 1'b0}) >> 24);
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e <= 10'd127) return 32'd0;
    if (e >= 10'd382) return {s, 8'hFF, 23'd0};
    e = e - 10'd127;
    return {s, e[7:0], f};
  endfunction

  // Truncating FP32 a - b. No guard bits: the smaller operand loses its
  // shifted-out bits before the add/subtract.
  function automatic logic [31:0] fp_sub(input logic [31:0] a, input logic [31:0] b);
    logic        s_big, s_sml;
    logic [7:0]  ea, eb, e_big, e_sml;
    logic [23:0] ma, mb, m_big, m_sml;
    logic [24:0] acc;
    logic [4:0]  lz;
    logic        hit;
    logic [8:0]  e_n;
    ea = a[30:23];
    eb = b[30:23];
    ma = (ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
    mb = (eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
    if ({ea, ma} >= {eb, mb}) begin
      s_big = a[31];  e_big = ea; m_big = ma;
      s_sml = ~b[31]; e_sml = eb; m_sml = mb;
    end else begin
      s_big = ~b[31]; e_big = eb; m_big = mb;
      s_sml = a[31];  e_sml = ea; m_sml = ma;
    end
    m_sml = m_sml >> (e_big - e_sml);
    acc = (s_big == s_sml) ? {1'b0, m_big} + {1'b0, m_sml}
                           : {1'b0, m_big} - {1'b0, m_sml};
    if (acc == 25'd0) return 32'd0;
    if (acc[24]) begin
      e_n = {1'b0, e_big} + 9'd1;
      if (e_n >= 9'd255) return {s_big, 8'hFF, 23'd0};
      return {s_big, e_n[7:0], acc[23:1]};
    end
    lz  = 5'd0;
    hit = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!hit) begin
        if (acc[i]) hit = 1'b1;
        else        lz  = lz + 5'd1;
      end
    end
    acc = acc << lz;
    if ({1'b0, e_big} <= {4'd0, lz}) return 32'd0;
    e_n = {1'b0, e_big} - {4'd0, lz};
    return {s_big, e_n[7:0], acc[22:0]};
  endfunction

  state_e      state_q, state_d;
  logic [31:0] x2_q, x2_d;       // x/2
  logic [31:0] y_q, y_d;         // running estimate, or the special result
  logic [31:0] t_q, t_d;         // holds t after MUL_A/MUL_B, d after SUB
  logic [2:0]  k_q, k_d;
  logic        spec_q, spec_d;

  logic [31:0] mul_a, mul_r, sub_r, in_spec_val;
  logic        in_spec;
  logic [2:0]  k_nxt;

  // Special-case classification of the incoming word; NaN before the sign
  // test so negative NaNs still map to the quiet NaN.
  always_comb begin
    in_spec     = 1'b1;
    in_spec_val = FP_QNAN;
    if (s_data[30:23] == 8'hFF && s_data[22:0] != 23'd0) in_spec_val = FP_QNAN;
    else if (s_data[30:23] == 8'd0)                      in_spec_val = FP_INF;
    else if (s_data[31])                                 in_spec_val = FP_QNAN;
    else if (s_data[30:23] == 8'hFF)                     in_spec_val = 32'd0;
    else                                                 in_spec     = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    x2_d    = x2_q;
    y_d     = y_q;
    t_d     = t_q;
    k_d     = k_q;
    spec_d  = spec_q;
    k_nxt   = k_q + 3'd1;
    mul_a   = (state_q == MUL_A) ? x2_q : t_q;
    mul_r   = fp_mul(mul_a, y_q);
    sub_r   = fp_sub(FP_1P5, t_q);
    case (state_q)
      IDLE: if (s_valid) begin
        k_d    = 3'd0;
        t_d    = 32'd0;
        spec_d = in_spec;
        if (in_spec) begin
          y_d     = in_spec_val;
          state_d = DONE;
        end else begin
          // exponent 1 would become a denormal: flush to zero instead
          x2_d    = (s_data[30:23] == 8'd1) ? 32'd0
                  : {s_data[31], s_data[30:23] - 8'd1, s_data[22:0]};
          y_d     = MAGIC - (s_data >> 1);
          state_d = MUL_A;
        end
      end
      MUL_A: begin t_d = mul_r; state_d = MUL_B; end
      MUL_B: begin t_d = mul_r; state_d = SUB;   end
      SUB:   begin t_d = sub_r; state_d = MUL_C; end
      MUL_C: begin
        y_d     = mul_r;
        k_d     = k_nxt;
        state_d = (k_nxt < ITER_W) ? MUL_A : DONE;
      end
      DONE:    if (m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x2_q    <= 32'd0;
      y_q     <= 32'd0;
      t_q     <= 32'd0;
      k_q     <= 3'd0;
      spec_q  <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      x2_q    <= x2_d;
      y_q     <= y_d;
      t_q     <= t_d;
      k_q     <= k_d;
      spec_q  <= spec_d;
    end
  end

  assign s_ready   = (state_q == IDLE);
  assign m_valid   = (state_q == DONE);
  assign m_data    = m_valid ? y_q : 32'd0;
  assign m_special = m_valid & spec_q;

endmodule
